// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame constants for the SPI master.
package spi_pkg;
    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, HOLD, GAP} state_t;
    localparam int SPI_FRAME_BITS = 8;
    localparam int MIN_CLK_DIV = 4;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: strobes phase_end every CLK_DIV cycles; clear restarts the phase.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] div_cnt;
    assign phase_end = div_cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= (clear || phase_end) ? '0 : div_cnt + W'(1);
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, MSB first, 8-bit frames, bursts held under one ssel.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);
    if (CLK_DIV < MIN_CLK_DIV || CLK_DIV > 255) begin : g_bad_div
        $error("spi_master: CLK_DIV out of range");
    end
    state_t     state;
    logic [6:0] tx_sh;
    logic [6:0] rx_sh;
    logic [2:0] bit_cnt;
    logic       last;
    logic       miso_m;
    logic       miso_s;
    logic       phase_end;
    logic       accept;
    assign accept = (state == IDLE || state == WAIT) && tx_valid && tx_ready;
    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .phase_end(phase_end)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_m <= 1'b0;
            miso_s <= 1'b0;
        end else begin
            miso_m <= miso;
            miso_s <= miso_m;
        end
    end
    // tx_sh holds only the bits not yet on mosi; bit 7 goes out at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            last     <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ssel     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                tx_sh    <= tx_data[6:0];
                last     <= tx_last;
                mosi     <= tx_data[7];
                ssel     <= 1'b0;
                busy     <= 1'b1;
                tx_ready <= 1'b0;
                bit_cnt  <= '0;
                state    <= LOW;
            end else begin
                case (state)
                    IDLE: tx_ready <= 1'b1;
                    LOW: if (phase_end) begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end
                    HIGH: if (phase_end) begin
                        sclk    <= 1'b0;
                        rx_sh   <= {rx_sh[5:0], miso_s};
                        tx_sh   <= {tx_sh[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(SPI_FRAME_BITS - 1)) begin
                            rx_valid <= 1'b1;
                            rx_data  <= {rx_sh, miso_s};
                            tx_ready <= !last;
                            state    <= last ? HOLD : WAIT;
                        end else begin
                            mosi  <= tx_sh[6];
                            state <= LOW;
                        end
                    end
                    HOLD: if (phase_end) begin
                        ssel  <= 1'b1;
                        state <= GAP;
                    end
                    GAP: if (phase_end) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of the SPI master at CLK_DIV=4 and CLK_DIV=7.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_txd = '0, a_rxd;
    logic a_last = 1'b0, a_valid = 1'b0;
    logic a_ready, a_rxv, a_busy, a_sclk, a_mosi, a_miso, a_ssel;
    logic [7:0] b_txd = '0, b_rxd;
    logic b_last = 1'b1, b_valid = 1'b0;
    logic b_ready, b_rxv, b_busy, b_sclk, b_mosi, b_ssel;

    logic       a_loop = 1'b0;
    logic [7:0] s_byte = '0;
    int         a_falls = 0, f0 = 0;
    always @(negedge a_sclk) a_falls++;
    assign a_miso = a_loop ? a_mosi : s_byte[3'(7 - (a_falls - f0))];

    spi_master #(.CLK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_txd), .tx_last(a_last), .tx_valid(a_valid),
        .tx_ready(a_ready), .rx_data(a_rxd), .rx_valid(a_rxv), .busy(a_busy),
        .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .ssel(a_ssel)
    );
    spi_master #(.CLK_DIV(7)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_txd), .tx_last(b_last), .tx_valid(b_valid),
        .tx_ready(b_ready), .rx_data(b_rxd), .rx_valid(b_rxv), .busy(b_busy),
        .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi), .ssel(b_ssel)
    );

    int n_cmp = 0, n_bad = 0;
    int a_rxv_cnt = 0, a_ssel_cnt = 0;
    always @(negedge clk) begin
        if (a_rxv) a_rxv_cnt++;
        if (a_ssel) a_ssel_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns in the cycle right after the accepting edge
    task automatic send_a(input logic [7:0] d, input logic l);
        int i = 0;
        while (!a_ready && i < 500) begin tick(); i++; end
        check("ready", a_ready, 1);
        a_txd = d; a_last = l; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_txd = 8'($urandom);
    endtask

    task automatic wait_rx_a(output int c);
        c = 0;
        while (!a_rxv && c < 2000) begin tick(); c++; end
        check("rx_seen", a_rxv, 1);
    endtask

    logic r_ssel [1:80], r_sclk [1:80], r_mosi [1:80], r_rxv [1:80], r_rdy [1:80];

    initial begin
        logic [7:0] rx65, d;
        int c, bad, s0, r0, rises, g, run, tr;
        logic prev;
        repeat (3) tick();
        check("rst_ssel", a_ssel, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_mosi", a_mosi, 0);
        check("rst_rxv", a_rxv, 0);
        check("rst_busy", a_busy, 0);
        check("rst_rxd", a_rxd, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", a_ready, 1);
        bad = 0;
        repeat (10) begin
            tick();
            if (a_ssel !== 1 || a_sclk !== 0 || a_mosi !== 0 || a_busy !== 0 || a_rxv !== 0) bad++;
        end
        check("idle_stable", bad, 0);

        // single byte 0xA5 out, slave answers 0x3C
        s_byte = 8'h3C; f0 = a_falls;
        send_a(8'hA5, 1'b1);
        rx65 = '0;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) tick();
            r_ssel[k] = a_ssel; r_sclk[k] = a_sclk; r_mosi[k] = a_mosi;
            r_rxv[k] = a_rxv; r_rdy[k] = a_ready;
            if (k == 65) rx65 = a_rxd;
        end
        check("ssel_c1", r_ssel[1], 0);
        d = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            check($sformatf("sclk_bit%0d", b),
                  {r_sclk[4+8*b], r_sclk[5+8*b], r_sclk[8+8*b], r_sclk[9+8*b]}, 4'b0110);
            check($sformatf("mosi_bit%0d", b), r_mosi[5+8*b], d[7-b]);
        end
        c = 0;
        for (int k = 1; k <= 80; k++) if (r_rxv[k]) c++;
        check("rxv_c65", r_rxv[65], 1);
        check("rxv_count", c, 1);
        check("rx_data_3c", rx65, 8'h3C);
        check("ssel_c68", r_ssel[68], 0);
        check("ssel_c69", r_ssel[69], 1);
        check("ready_c72", r_rdy[72], 0);
        check("ready_c73", r_rdy[73], 1);

        // two-byte burst in loopback
        a_loop = 1'b1;
        send_a(8'h01, 1'b0);
        s0 = a_ssel_cnt;
        wait_rx_a(c);
        check("burst_rx0", a_rxd, 8'h01);
        check("wait_ready", a_ready, 1);
        send_a(8'h80, 1'b1);
        wait_rx_a(c);
        check("burst_spacing", c + 1, 65);
        check("burst_rx1", a_rxd, 8'h80);
        check("burst_ssel_low", a_ssel_cnt - s0, 0);

        // stall in WAIT
        send_a(8'h5A, 1'b0);
        wait_rx_a(c);
        check("stall_rx", a_rxd, 8'h5A);
        bad = 0;
        repeat (100) begin
            tick();
            if (a_ssel !== 0 || a_sclk !== 0 || a_ready !== 1) bad++;
        end
        check("wait_stall", bad, 0);
        send_a(8'h33, 1'b1);
        c = 1;
        while (!a_sclk && c < 100) begin tick(); c++; end
        check("wait_first_rise", c, 5);
        wait_rx_a(c);
        check("after_stall_rx", a_rxd, 8'h33);

        // reset after the third sclk rise
        send_a(8'hC3, 1'b1);
        rises = 0; prev = 1'b0; g = 0;
        while (rises < 3 && g < 500) begin
            tick(); g++;
            if (a_sclk && !prev) rises++;
            prev = a_sclk;
        end
        repeat (2) tick();
        r0 = a_rxv_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_ssel", a_ssel, 1);
        check("midrst_sclk", a_sclk, 0);
        check("midrst_busy", a_busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("midrst_no_rxv", a_rxv_cnt - r0, 0);
        send_a(8'h96, 1'b1);
        wait_rx_a(c);
        check("post_rst_rx", a_rxd, 8'h96);

        for (int f = 0; f < 3; f++) begin
            d = 8'($urandom);
            send_a(d, 1'b1);
            wait_rx_a(c);
            check("rand4_rx", a_rxd, d);
        end

        // CLK_DIV=7 loopback with sclk width measurement
        for (int f = 0; f < 4; f++) begin
            d = 8'($urandom);
            g = 0;
            while (!b_ready && g < 500) begin tick(); g++; end
            check("b_ready", b_ready, 1);
            b_txd = d; b_valid = 1'b1;
            tick();
            b_valid = 1'b0;
            run = 1; prev = b_sclk; bad = 0; tr = 0; g = 0;
            while (!b_rxv && g < 1000) begin
                tick(); g++;
                if (b_sclk !== prev) begin
                    tr++;
                    if (run != 7) bad++;
                    run = 1;
                    prev = b_sclk;
                end else run++;
            end
            check("b_rx", b_rxd, d);
            check("b_width", bad, 0);
            check("b_edges", tr, 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
